sum_display_scan: RTL and testbench

SUM_DISPLAY_SCAN -- requirements
Module: sum_display_scan

---
 rtl/disp_pkg.sv | 19 +
 rtl/sum_display_scan_if.sv | 16 +
 rtl/hex7seg.sv | 11 +
 rtl/sum_display_scan.sv | 83 ++++++++
 tb/tb_sum_display_scan.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and types for the summed-value display scanner
package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;

  typedef logic [3:0]       hex_t;
  typedef logic [0:SEG_W-1] seg_t;   // index 0 = segment a, 6 = segment g, 0 = lit

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/sum_display_scan_if.sv
// rtl/sum_display_scan_if.sv - capture/control inputs and multiplexed display outputs
interface sum_display_scan_if;
  import disp_pkg::*;

  hex_t       value_in;
  logic       value_valid;
  logic       clear;
  logic       hold;
  seg_t       leds;
  logic [3:0] an;
  logic       dp;

  modport master (output value_in, value_valid, clear, hold, input leds, an, dp);
  modport slave  (input value_in, value_valid, clear, hold, output leds, an, dp);

endinterface

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex digit to active-low seven-segment decoder
module hex7seg
  import disp_pkg::*;
(
  input  hex_t hex_i,
  output seg_t seg_o
);

  assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/sum_display_scan.sv
// rtl/sum_display_scan.sv - 4-deep result history scanned onto a multiplexed 7-seg display
// Optional macro BLANK_UNUSED_EN blanks digits not yet filled since reset/clear.
module sum_display_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic               clock,
  input  logic               reset,
  sum_display_scan_if.slave  bus
);

  localparam int PW = (SCAN_DIV <= 2) ? 1 : $clog2(SCAN_DIV);

`ifdef BLANK_UNUSED_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  hex_t          hist_q [NUM_DIGITS];
  hex_t          hist_d [NUM_DIGITS];
  logic [2:0]    cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  seg_t          leds_q, leds_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  seg_t          seg_w;
  logic          term_w;

  // clear beats hold, hold beats a capture strobe
  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (bus.clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) hist_d[i] = '0;
      cnt_d = '0;
    end else if (bus.value_valid && !bus.hold) begin
      hist_d[0] = bus.value_in;
      for (int i = 1; i < NUM_DIGITS; i++) hist_d[i] = hist_q[i-1];
      cnt_d = (cnt_q == 3'd4) ? cnt_q : cnt_q + 3'd1;
    end
  end

  assign term_w  = (presc_q == PW'(SCAN_DIV - 1));
  assign presc_d = term_w ? '0 : presc_q + 1'b1;
  assign idx_d   = term_w ? idx_q + 2'd1 : idx_q;

  hex7seg u_dec (
    .hex_i (hist_q[idx_q]),
    .seg_o (seg_w)
  );

  assign leds_d = (BLANK_EN && ({1'b0, idx_q} >= cnt_q)) ? SEG_BLANK : seg_w;
  assign an_d   = ~(4'b0001 << idx_q);
  assign dp_d   = (idx_q != 2'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) hist_q[i] <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      leds_q  <= SEG_BLANK;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) hist_q[i] <= hist_d[i];
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      leds_q  <= leds_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.leds = leds_q;
  assign bus.an   = an_q;
  assign bus.dp   = dp_q;

endmodule

// File: tb/tb_sum_display_scan.sv
// tb/tb_sum_display_scan.sv - directed self-checking bench for sum_display_scan (SCAN_DIV=4)
module tb_sum_display_scan;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef BLANK_UNUSED_EN
  localparam logic [6:0] EXP_UNUSED = 7'b1111111;
`else
  localparam logic [6:0] EXP_UNUSED = 7'b0000001;
`endif

  sum_display_scan_if bus ();

  sum_display_scan #(.SCAN_DIV(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic strobe(input logic [3:0] v);
    @(negedge clock);
    bus.value_in    = v;
    bus.value_valid = 1'b1;
    @(negedge clock);
    bus.value_valid = 1'b0;
  endtask

  task automatic wait_digit(input int d, output bit ok);
    logic [3:0] want;
    int         i;
    want = ~(4'b0001 << d);
    ok   = 1'b0;
    i    = 0;
    while (!ok && i < 40) begin
      @(negedge clock);
      if (bus.an === want) ok = 1'b1;
      i++;
    end
  endtask

  task automatic check_digit(input int d, input logic [6:0] exp, input string name);
    bit         ok;
    logic [6:0] got;
    wait_digit(d, ok);
    got = bus.leds;
    n_checks++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL %s digit%0d: leds=%b an=%b reached=%0d, expected leds=%b", name, d, got, bus.an, ok, exp);
    end
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if (bus.leds !== 7'b1111111) begin n_fail++; $display("FAIL reset_leds: got %b expected 1111111", bus.leds); end
    n_checks++;
    if (bus.an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", bus.an); end
    n_checks++;
    if (bus.dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", bus.dp); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (bus.an !== 4'b1110) begin n_fail++; $display("FAIL release_an: got %b expected 1110", bus.an); end
    n_checks++;
    if (bus.dp !== 1'b0) begin n_fail++; $display("FAIL release_dp: got %b expected 0", bus.dp); end
  endtask

  task automatic test_scan;
    logic [3:0] exp_an;
    @(negedge clock);
    reset = 1'b0;
    #2 reset = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clock);
      exp_an = ~(4'b0001 << (((n - 1) / 4) % 4));
      n_checks++;
      if (bus.an !== exp_an || bus.dp !== (exp_an != 4'b1110)) begin
        n_fail++;
        $display("FAIL scan cycle %0d: an=%b dp=%b expected an=%b", n, bus.an, bus.dp, exp_an);
      end
    end
  endtask

  task automatic test_capture;
    strobe(4'h5);
    strobe(4'hA);
    strobe(4'h3);
    strobe(4'hC);
    strobe(4'h7);
    check_digit(0, 7'b0001111, "capture");
    check_digit(1, 7'b0110001, "capture");
    check_digit(2, 7'b0000110, "capture");
    check_digit(3, 7'b0001000, "capture");
  endtask

  task automatic test_hold;
    @(negedge clock);
    bus.hold = 1'b1;
    strobe(4'hF);
    check_digit(0, 7'b0001111, "hold_on");
    check_digit(3, 7'b0001000, "hold_on");
    @(negedge clock);
    bus.hold = 1'b0;
    strobe(4'hF);
    check_digit(0, 7'b0111000, "hold_off");
    check_digit(1, 7'b0001111, "hold_off");
    check_digit(3, 7'b0000110, "hold_off");
  endtask

  task automatic test_clear;
    @(negedge clock);
    bus.hold        = 1'b1;
    bus.clear       = 1'b1;
    bus.value_valid = 1'b1;
    bus.value_in    = 4'h9;
    @(negedge clock);
    bus.clear       = 1'b0;
    bus.value_valid = 1'b0;
    bus.hold        = 1'b0;
    for (int d = 0; d < 4; d++) check_digit(d, EXP_UNUSED, "clear");
  endtask

  task automatic test_partial_fill;
    strobe(4'h2);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.an !== 4'b1111 || bus.leds !== 7'b1111111 || bus.dp !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reset: an=%b leds=%b dp=%b expected 1111 1111111 1", bus.an, bus.leds, bus.dp);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (bus.an !== 4'b1110) begin n_fail++; $display("FAIL midrun_release_an: got %b expected 1110", bus.an); end
    strobe(4'h8);
    check_digit(0, 7'b0000000, "partial");
    for (int d = 1; d < 4; d++) check_digit(d, EXP_UNUSED, "partial");
  endtask

  initial begin
    bus.value_in    = 4'h0;
    bus.value_valid = 1'b0;
    bus.clear       = 1'b0;
    bus.hold        = 1'b0;
    test_reset();
    test_scan();
    test_capture();
    test_hold();
    test_clear();
    test_partial_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
